// File: rtl/password_lock_ctrl_if.sv
// Keypad/status bundle for password_lock_ctrl: key strobe toward the lock, lock status back.
interface password_lock_ctrl_if;
    logic       key_pressed;
    logic [3:0] key_value;
    logic       unlock;
    logic       alarm;
    logic [1:0] fail_cnt;
    logic [2:0] digit_cnt;
    logic [2:0] state;

    modport master (output key_pressed, key_value,
                    input  unlock, alarm, fail_cnt, digit_cnt, state);
    modport slave  (input  key_pressed, key_value,
                    output unlock, alarm, fail_cnt, digit_cnt, state);
endinterface

// File: rtl/password_lock_ctrl.sv
// Four-digit keypad lock with failure lockout and timed unlock.
// Define PW_CHANGE_EN to allow changing the stored password from UNLOCKED.
module password_lock_ctrl #(
    parameter logic [15:0] DEFAULT_PW    = 16'h1234,
    parameter int          MAX_FAIL      = 3,
    parameter int          UNLOCK_CYCLES = 500,
    parameter int          LOCK_CYCLES   = 1000
) (
    input logic                 clk,
    input logic                 rst_n,
    password_lock_ctrl_if.slave bus
);
    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_CHECK    = 3'd1,
        S_UNLOCKED = 3'd2,
        S_LOCKOUT  = 3'd3,
        S_NEWPW    = 3'd4
    } state_t;

    localparam int             TMAX        = (UNLOCK_CYCLES > LOCK_CYCLES) ? UNLOCK_CYCLES : LOCK_CYCLES;
    localparam int             TW          = $clog2(TMAX);
    localparam logic [TW-1:0]  UNLOCK_LAST = TW'(UNLOCK_CYCLES - 1);
    localparam logic [TW-1:0]  LOCK_LAST   = TW'(LOCK_CYCLES - 1);
    localparam logic [1:0]     FAIL_LIMIT  = 2'(MAX_FAIL);

    state_t        r_state;
    logic          r_unlock;
    logic          r_alarm;
    logic [1:0]    r_fail_cnt;
    logic [2:0]    r_digit_cnt;
    logic [15:0]   r_entry;
    logic [TW-1:0] r_timer;

    logic          w_digit;
    logic          w_enter;
    logic          w_clear;
    logic          w_room;
    logic          w_pass;
    logic [3:0]    w_slot;
    logic [1:0]    w_fail_next;
    logic [15:0]   w_pw;

    assign w_digit     = bus.key_pressed && (bus.key_value <= 4'd9);
    assign w_enter     = bus.key_pressed && (bus.key_value == 4'hA);
    assign w_clear     = bus.key_pressed && (bus.key_value == 4'hB);
    assign w_room      = (r_digit_cnt != 3'd4);
    // digit0 lands in the top nibble, so slot n sits at bit 4*(3-n)
    assign w_slot      = {2'd3 - r_digit_cnt[1:0], 2'b00};
    assign w_pass      = (r_digit_cnt == 3'd4) && (r_entry == w_pw);
    assign w_fail_next = (r_fail_cnt == FAIL_LIMIT) ? r_fail_cnt : r_fail_cnt + 2'd1;

`ifdef PW_CHANGE_EN
    logic        w_change;
    logic [15:0] r_pw;
    assign w_change = bus.key_pressed && (bus.key_value == 4'hC);
    assign w_pw     = r_pw;
`else
    assign w_pw     = DEFAULT_PW;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_unlock    <= 1'b0;
            r_alarm     <= 1'b0;
            r_fail_cnt  <= 2'd0;
            r_digit_cnt <= 3'd0;
            r_entry     <= 16'h0;
            r_timer     <= '0;
`ifdef PW_CHANGE_EN
            r_pw        <= DEFAULT_PW;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_digit) begin
                        if (w_room) begin
                            r_entry[w_slot +: 4] <= bus.key_value;
                            r_digit_cnt          <= r_digit_cnt + 3'd1;
                        end
                    end else if (w_clear) begin
                        r_digit_cnt <= 3'd0;
                        r_entry     <= 16'h0;
                    end else if (w_enter) begin
                        r_state <= S_CHECK;
                    end
                end
                S_CHECK: begin
                    r_digit_cnt <= 3'd0;
                    r_entry     <= 16'h0;
                    r_timer     <= '0;
                    if (w_pass) begin
                        r_state    <= S_UNLOCKED;
                        r_unlock   <= 1'b1;
                        r_fail_cnt <= 2'd0;
                    end else begin
                        r_fail_cnt <= w_fail_next;
                        if (w_fail_next == FAIL_LIMIT) begin
                            r_state <= S_LOCKOUT;
                            r_alarm <= 1'b1;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_UNLOCKED: begin
                    // timeout takes priority so the open window never exceeds UNLOCK_CYCLES
                    if (w_clear || (r_timer == UNLOCK_LAST)) begin
                        r_state  <= S_IDLE;
                        r_unlock <= 1'b0;
                    end
`ifdef PW_CHANGE_EN
                    else if (w_change) begin
                        r_state     <= S_NEWPW;
                        r_unlock    <= 1'b0;
                        r_digit_cnt <= 3'd0;
                        r_entry     <= 16'h0;
                    end
`endif
                    else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                S_LOCKOUT: begin
                    if (r_timer == LOCK_LAST) begin
                        r_state    <= S_IDLE;
                        r_alarm    <= 1'b0;
                        r_fail_cnt <= 2'd0;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
`ifdef PW_CHANGE_EN
                S_NEWPW: begin
                    if (w_digit) begin
                        if (w_room) begin
                            r_entry[w_slot +: 4] <= bus.key_value;
                            r_digit_cnt          <= r_digit_cnt + 3'd1;
                        end
                    end else if (w_clear || w_enter) begin
                        if (w_enter && !w_room)
                            r_pw <= r_entry;
                        r_state     <= S_IDLE;
                        r_digit_cnt <= 3'd0;
                        r_entry     <= 16'h0;
                    end
                end
`endif
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.unlock    = r_unlock;
    assign bus.alarm     = r_alarm;
    assign bus.fail_cnt  = r_fail_cnt;
    assign bus.digit_cnt = r_digit_cnt;
    assign bus.state     = r_state;
endmodule

// File: tb/tb_password_lock_ctrl.sv
// Bench for password_lock_ctrl: directed scenarios plus random keys against a countdown/queue model.
module tb_password_lock_ctrl;
    localparam int UC = 500;
    localparam int LC = 1000;
    localparam int MF = 3;
`ifdef PW_CHANGE_EN
    localparam bit PWC = 1'b1;
`else
    localparam bit PWC = 1'b0;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   tests = 0;
    int   fails = 0;

    password_lock_ctrl_if bus();

    password_lock_ctrl #(
        .DEFAULT_PW(16'h1234), .MAX_FAIL(MF), .UNLOCK_CYCLES(UC), .LOCK_CYCLES(LC)
    ) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    always #5 clk = ~clk;

    // Model: entered digits as a queue, open/lockout windows as countdowns.
    int m_q[$];
    int m_pw[4];
    bit m_pend, m_new;
    int m_ul, m_ll, m_fail;

    task automatic model_reset();
        m_q.delete();
        m_pw   = '{1, 2, 3, 4};
        m_pend = 1'b0;
        m_new  = 1'b0;
        m_ul   = 0;
        m_ll   = 0;
        m_fail = 0;
    endtask

    task automatic model_step(input bit kp, input int k);
        bit pass;
        if (m_pend) begin
            pass = (m_q.size() == 4);
            if (pass) for (int i = 0; i < 4; i++) if (m_q[i] != m_pw[i]) pass = 1'b0;
            m_pend = 1'b0;
            m_q.delete();
            if (pass) begin
                m_fail = 0;
                m_ul   = UC;
            end else begin
                m_fail = (m_fail < MF) ? m_fail + 1 : MF;
                if (m_fail == MF) m_ll = LC;
            end
        end else if (m_ul > 0) begin
            if (kp && k == 11)               m_ul = 0;
            else if (m_ul == 1)              m_ul = 0;
            else if (PWC && kp && k == 12) begin
                m_ul  = 0;
                m_new = 1'b1;
                m_q.delete();
            end else                         m_ul--;
        end else if (m_ll > 0) begin
            m_ll--;
            if (m_ll == 0) m_fail = 0;
        end else if (kp) begin
            if (k <= 9) begin
                if (m_q.size() < 4) m_q.push_back(k);
            end else if (k == 11) begin
                m_q.delete();
                m_new = 1'b0;
            end else if (k == 10) begin
                if (m_new) begin
                    if (m_q.size() == 4) for (int i = 0; i < 4; i++) m_pw[i] = m_q[i];
                    m_q.delete();
                    m_new = 1'b0;
                end else begin
                    m_pend = 1'b1;
                end
            end
        end
    endtask

    initial model_reset();

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_reset();
        else        model_step(bus.key_pressed, int'(bus.key_value));
    end

    always @(negedge clk) begin
        int e_st;
        if (rst_n) begin
            e_st = m_pend ? 1 : (m_ul > 0) ? 2 : (m_ll > 0) ? 3 : m_new ? 4 : 0;
            tests++;
            if (bus.unlock !== (m_ul > 0) || bus.alarm !== (m_ll > 0) ||
                int'(bus.fail_cnt) != m_fail || int'(bus.digit_cnt) != m_q.size() ||
                int'(bus.state) != e_st) begin
                fails++;
                $display("FAIL model_cmp t=%0t got unl=%0b alm=%0b fc=%0d dc=%0d st=%0d exp unl=%0b alm=%0b fc=%0d dc=%0d st=%0d",
                         $time, bus.unlock, bus.alarm, bus.fail_cnt, bus.digit_cnt, bus.state,
                         (m_ul > 0), (m_ll > 0), m_fail, m_q.size(), e_st);
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", name, got, exp, $time);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_unlock"}, int'(bus.unlock), 0);
        chk({name, "_alarm"},  int'(bus.alarm), 0);
        chk({name, "_fail"},   int'(bus.fail_cnt), 0);
        chk({name, "_dcnt"},   int'(bus.digit_cnt), 0);
        chk({name, "_state"},  int'(bus.state), 0);
    endtask

    // Called at negedge+2; the key is sampled at the next posedge, returns at negedge+2.
    task automatic press(input int k);
        bus.key_pressed = 1'b1;
        bus.key_value   = 4'(k);
        @(negedge clk); #2;
        bus.key_pressed = 1'b0;
    endtask

    task automatic press_seq(input int a, input int b, input int c, input int d);
        press(a); press(b); press(c); press(d); press(10);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(negedge clk); #2; end
    endtask

    task automatic reset_pulse(input string name);
        #1 rst_n = 1'b0;
        #1 chk_zero(name);
        @(negedge clk); #1 rst_n = 1'b1;
        #1;
    endtask

    // Count consecutive cycles the chosen level is high; random keys are fed during alarm.
    task automatic count_level(input bit alarm_sel, output int n);
        bit lvl;
        n = 0;
        while (n < LC + 10) begin
            @(negedge clk); #1;
            lvl = alarm_sel ? bus.alarm : bus.unlock;
            if (!lvl) break;
            n++;
            if (alarm_sel) begin
                bus.key_pressed = 1'b1;
                bus.key_value   = 4'($urandom_range(0, 15));
            end
        end
        #1 bus.key_pressed = 1'b0;
    endtask

    initial begin
        int n;
        bus.key_pressed = 1'b0;
        bus.key_value   = 4'h0;
        repeat (2) @(negedge clk);
        #2 chk_zero("reset");
        @(negedge clk); #1 rst_n = 1'b1;
        #1;

        // first key right after release, then a correct entry
        press(1);
        chk("first_key_dcnt", int'(bus.digit_cnt), 1);
        press(2); press(3); press(4); press(10);
        chk("check_state", int'(bus.state), 1);
        count_level(1'b0, n);
        chk("unlock_len", n, UC);
        chk("after_unlock_state", int'(bus.state), 0);

        // three wrong entries -> lockout
        for (int i = 0; i < 3; i++) begin
            press_seq(1, 2, 3, 5);
            if (i < 2) begin
                idle(1);
                chk("fail_cnt_step", int'(bus.fail_cnt), i + 1);
            end
        end
        count_level(1'b1, n);
        chk("alarm_len", n, LC);
        chk("lock_end_fail", int'(bus.fail_cnt), 0);
        chk("lock_end_state", int'(bus.state), 0);

        // short entry fails; clear then correct entry passes and clears fail_cnt
        press(1); press(2); press(10);
        idle(1);
        chk("short_fail", int'(bus.fail_cnt), 1);
        press(1); press(2); press(11);
        chk("clear_dcnt", int'(bus.digit_cnt), 0);
        press_seq(1, 2, 3, 4);
        idle(1);
        chk("retry_unlock", int'(bus.unlock), 1);
        chk("retry_fail", int'(bus.fail_cnt), 0);
        press(11);
        chk("clear_unlocked", int'(bus.state), 0);

        // extra digits ignored
        press(1); press(2); press(3); press(4); press(5); press(6);
        chk("overflow_dcnt", int'(bus.digit_cnt), 4);
        press(10);
        count_level(1'b0, n);
        chk("overflow_unlock_len", n, UC);

`ifdef PW_CHANGE_EN
        press_seq(1, 2, 3, 4);
        idle(1);
        press(12);
        chk("newpw_state", int'(bus.state), 4);
        chk("newpw_unlock", int'(bus.unlock), 0);
        press_seq(9, 8, 7, 6);
        chk("newpw_done", int'(bus.state), 0);
        press_seq(1, 2, 3, 4);
        idle(1);
        chk("old_pw_fails", int'(bus.fail_cnt), 1);
        press_seq(9, 8, 7, 6);
        idle(1);
        chk("new_pw_unlocks", int'(bus.unlock), 1);
        press(12); press(5);
        reset_pulse("rst_newpw");
        press_seq(1, 2, 3, 4);
        idle(1);
        chk("default_after_rst", int'(bus.unlock), 1);
        press(11);
`endif

        // reset in the middle of lockout
        for (int i = 0; i < 3; i++) begin
            press_seq(1, 2, 3, 5);
            idle(1);
        end
        idle(20);
        chk("mid_lock_alarm", int'(bus.alarm), 1);
        reset_pulse("rst_lockout");
        press_seq(1, 2, 3, 4);
        idle(1);
        chk("unlock_after_rst", int'(bus.unlock), 1);
        press(11);

        // random traffic, occasionally typing the current password or pulsing reset
        for (int i = 0; i < 6000; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                press_seq(m_pw[0], m_pw[1], m_pw[2], m_pw[3]);
            end else if (r < 60) begin
                press($urandom_range(0, 15));
            end else if (r == 60 && ($urandom_range(0, 19) == 0)) begin
                reset_pulse("rand_rst");
            end else begin
                idle(1);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
